// File: rtl/psr_unit.sv
// LC-3 Processor Status Register: privilege, priority and NZP storage,
// plus the registered branch-enable and interrupt-pending flags.
module psr_unit #(
  parameter logic [15:0] RESET_PSR = 16'h8002
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_LD_CC,
  input  logic        i_LD_PSR,
  input  logic        i_LD_Priv,
  input  logic        i_Priv_In,
  input  logic        i_LD_Priority,
  input  logic [2:0]  i_Priority_In,
  input  logic        i_LD_BEN,
  input  logic [2:0]  i_IR_CC,
  input  logic [15:0] i_Bus,
  input  logic        i_Int_Req,
  input  logic [2:0]  i_Int_Priority,
  output logic [15:0] o_PSR,
  output logic [2:0]  o_NZP,
  output logic        o_Priv,
  output logic        o_BEN,
  output logic        o_INT
);

  logic       r_priv;
  logic [2:0] r_priority;
  logic [2:0] r_nzp;
  logic       r_ben;
  logic       r_int;

  logic       w_bus_zero;
  logic [2:0] w_cc;
  logic       w_priv_next;
  logic [2:0] w_priority_next;
  logic [2:0] w_nzp_next;
  logic       w_ben_next;
  logic       w_int_next;

  assign w_bus_zero = (i_Bus == 16'h0000);
  assign w_cc       = {i_Bus[15], w_bus_zero, ~i_Bus[15] & ~w_bus_zero};

  // RTI restore owns every field; otherwise each field loads on its own strobe.
  always_comb begin
    w_priv_next     = r_priv;
    w_priority_next = r_priority;
    w_nzp_next      = r_nzp;
    if (i_LD_PSR) begin
      w_priv_next     = i_Bus[15];
      w_priority_next = i_Bus[10:8];
      w_nzp_next      = i_Bus[2:0];
    end else begin
      if (i_LD_Priv)     w_priv_next     = i_Priv_In;
      if (i_LD_Priority) w_priority_next = i_Priority_In;
      if (i_LD_CC)       w_nzp_next      = w_cc;
    end
  end

  // Both flags are computed from the pre-update register contents.
  assign w_ben_next = i_LD_BEN ? |(i_IR_CC & r_nzp) : r_ben;
  assign w_int_next = i_Int_Req && (i_Int_Priority > r_priority);

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_priv     <= RESET_PSR[15];
      r_priority <= RESET_PSR[10:8];
      r_nzp      <= RESET_PSR[2:0];
      r_ben      <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_priv     <= w_priv_next;
      r_priority <= w_priority_next;
      r_nzp      <= w_nzp_next;
      r_ben      <= w_ben_next;
      r_int      <= w_int_next;
    end
  end

  assign o_PSR  = {r_priv, 4'b0000, r_priority, 5'b00000, r_nzp};
  assign o_NZP  = r_nzp;
  assign o_Priv = r_priv;
  assign o_BEN  = r_ben;
  assign o_INT  = r_int;

endmodule
